// File: rtl/encoder_4to2_seq.sv
`default_nettype none
// ============================================================================
//  Module      : encoder_4to2_seq
//  Description : Sequential 4-to-2 priority encoder; one code beat per set bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module encoder_4to2_seq #(
  parameter int IN_W      = 4,
  parameter int OUT_W     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_code,
  output logic             out_last,
  output logic             out_none,
  output logic [2:0]       out_count
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  localparam logic [IN_W-1:0] c_one = {{(IN_W-1){1'b0}}, 1'b1};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IN_W-1:0]   r_pending;
  logic [IN_W-1:0]   w_pending_nxt;
  logic [IN_W-1:0]   w_clear;
  logic [OUT_W-1:0]  w_code;
  logic              w_last;
  logic              r_none;
  logic              w_none_nxt;
  logic [2:0]        r_count;
  logic [2:0]        w_count_nxt;
  logic              w_accept;
  logic              w_beat;

  function automatic logic [2:0] popcount(input logic [IN_W-1:0] v);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < IN_W; i++) s = s + {2'b00, v[i]};
    return s;
  endfunction

  // Later loop iterations override earlier ones, so scan order sets priority.
  generate
    if (MSB_FIRST != 0) begin : g_prio_msb
      always_comb begin
        w_code = '0;
        for (int i = 0; i < IN_W; i++)
          if (r_pending[i]) w_code = i[OUT_W-1:0];
      end
    end else begin : g_prio_lsb
      always_comb begin
        w_code = '0;
        for (int i = IN_W - 1; i >= 0; i--)
          if (r_pending[i]) w_code = i[OUT_W-1:0];
      end
    end
  endgenerate

  // At most one bit left (including none) means this is the final beat.
  assign w_last = ((r_pending & (r_pending - c_one)) == '0);

  always_comb begin
    w_clear         = '0;
    w_clear[w_code] = 1'b1;
  end

  assign w_accept = in_valid && (r_state == ST_IDLE);
  assign w_beat   = out_ready && (r_state == ST_SCAN);

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_none_nxt    = r_none;
    w_count_nxt   = r_count;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_pending_nxt = in_vec;
          w_none_nxt    = (in_vec == '0);
          w_count_nxt   = popcount(in_vec);
          w_state_nxt   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (w_beat) begin
          w_pending_nxt = r_pending & ~w_clear;
          if (w_last) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_none    <= 1'b0;
      r_count   <= 3'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_none    <= w_none_nxt;
      r_count   <= w_count_nxt;
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_SCAN);
  assign out_code  = out_valid ? w_code : '0;
  assign out_last  = out_valid && w_last;
  assign out_none  = r_none;
  assign out_count = r_count;

endmodule
`default_nettype wire

// File: doc/encoder_4to2_seq.md
Name: encoder_4to2_seq

Overview:
- Sequential 4-to-2 priority encoder; inverse of the 2-to-4 decoder in Encoders_Decoders.
- Accepts a 4-bit request vector over a valid/ready handshake.
- Emits one 2-bit code per set bit, highest priority first, over a second valid/ready handshake.
- Marks the last code of each vector, and reports an all-zero vector with a single flagged beat.

Parameters:
IN_W, 4, input vector width; fixed at 4 for this block.
OUT_W, 2, code width; must equal log2(IN_W).
MSB_FIRST, 1, 1 = bit 3 has highest priority; 0 = bit 0 has highest priority.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  in_vec is valid
in_ready  output  1  block can accept in_vec
in_vec  input  IN_W  request vector (multi-hot allowed)
out_valid  output  1  out_code is valid
out_ready  input  1  downstream accepts out_code
out_code  output  OUT_W  binary index of the current highest-priority pending bit
out_last  output  1  current beat is the final beat for this vector
out_none  output  1  accepted vector was all-zero; out_code is 0
out_count  output  3  popcount of the accepted vector (0..4), held for all beats

Behaviour:
- Reset (async assert, sync release): state=IDLE, pending=0, in_ready=1, out_valid=0, out_code=0, out_last=0, out_none=0, out_count=0.
  - Asserting reset mid-scan drops all pending bits immediately; no partial beat completes.
- States: IDLE, SCAN.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: pending<=in_vec, out_count<=popcount(in_vec), out_none<=(in_vec==0), then go to SCAN.
  - in_vec is sampled once; later changes are ignored.
- SCAN:
  - in_ready=0, out_valid=1.
  - out_code is combinational from pending: the highest set index if MSB_FIRST=1, the lowest set index if MSB_FIRST=0.
  - out_last=1 when pending has at most 1 bit set.
  - If pending==0 (zero vector): out_code=0, out_none=1, out_last=1.
  - On out_valid&&out_ready: clear the encoded bit in pending. If out_last, go to IDLE.
  - No beat is lost or repeated while out_ready=0; out_code, out_last and out_none stay stable.
- Latency and throughput:
  - Input accepted in cycle N gives first out_valid in cycle N+1.
  - With out_ready held at 1, a k-bit vector takes k cycles in SCAN (1 cycle for a zero vector), then 1 cycle in IDLE before the next accept.
  - Throughput is 1 input per (max(k,1)+1) cycles.
- No overlap: in_ready=0 throughout SCAN, including the final beat, so input and output never handshake in the same cycle.
- out_code is registered-stable: its value is a function of the pending register only and never depends on in_vec.
- out_none and out_count stay constant for all beats of one vector and hold their values in IDLE until the next accept.

Test Plan:
- Reset release, in_valid=0 -> in_ready=1, out_valid=0, all outputs 0. Assert rst_n=0 mid-scan -> out_valid drops asynchronously, then in_ready=1.
- in_vec=4'b1000, out_ready=1 -> one beat: out_code=2'b11, out_last=1, out_count=1; in_ready returns 1 the cycle after.
- in_vec=4'b1011, MSB_FIRST=1, out_ready=1 -> beats 2'b11, 2'b01, 2'b00; out_last only on the third beat; out_count=3.
  - Same vector with MSB_FIRST=0 -> beats 2'b00, 2'b01, 2'b11.
- in_vec=4'b0000 -> one beat with out_none=1, out_code=0, out_last=1, out_count=0.
- in_vec=4'b1111, out_ready toggled 1,0,0,1,1,1 -> 2'b11 accepted in cycle 1, 2'b10 held stable over 2 stall cycles, then 2'b10, 2'b01, 2'b00 accepted. Exactly 4 accepted beats; in_vec changes during SCAN are ignored.
- Back-to-back inputs 4'b0101 then 4'b0010 with in_valid held high -> second vector accepted only in the IDLE cycle after the last beat of the first. Code sequence: 2'b10, 2'b00, 2'b01.
